bp_be_late_wb_buffer: RTL and testbench
=======================================

// Module: bp_be_late_wb_buffer
// PURPOSE
//  Collects long-latency writebacks: integer/PTW data from D$ miss returns, and FP results from the fdiv/fsqrt unit.
//  Holds them in an in-order FIFO and presents one packet per cycle on the late-writeback port of the BE scheduler.
//  The scheduler dispatches a packet only into an issue bubble, unless this block raises force.
//  Force is raised when the buffer nears full or the head entry has starved.
// PARAMETERS
//  bp_params_p     e_bp_default_cfg  processor config; supplies vaddr_width_p -> wb_pkt_width_lp
//  els_p           4                 FIFO depth in packets, >=2, need not be a power of two
//  force_thresh_p  3                 occupancy (1..els_p) at or above which force_o is asserted
//  age_limit_p     16                head-entry wait cycles before age force (>=1); used only with the macro
// PORTS
//  clk_i            in   1                clock
//  reset_n_i        in   1                asynchronous active-low reset
//  ilong_pkt_i      in   wb_pkt_width_lp  integer/PTW late writeback (bp_be_wb_pkt_s)
//  ilong_v_i        in   1                ilong_pkt_i valid
//  ilong_ready_o    out  1                ilong source may present a packet (valid-ready)
//  flong_pkt_i      in   wb_pkt_width_lp  FP late writeback (bp_be_wb_pkt_s, fflags valid)
//  flong_v_i        in   1                flong_pkt_i valid
//  flong_ready_o    out  1                flong source may present a packet
//  late_wb_pkt_o    out  wb_pkt_width_lp  head packet
//  late_wb_v_o      out  1                head valid
//  late_wb_force_o  out  1                scheduler must accept this cycle and preempt issue
//  late_wb_yumi_i   in   1                head consumed this cycle; legal only when late_wb_v_o=1
//  occupancy_o      out  $clog2(els_p+1)  current entry count, for perf counters and debug
// BEHAVIOUR
//  Reset: reset_n_i low clears, asynchronously:
//   - rd/wr pointers and count to 0
//   - RR priority to ilong, age counter to 0
//  Outputs during and after reset:
//   - late_wb_v_o=0, late_wb_force_o=0, occupancy_o=0
//   - ilong_ready_o=flong_ready_o=1
//   - entry storage is not reset
//  Reset mid-operation drops every buffered packet. The BE is reset with it.
//  Enqueue: at most one packet per cycle.
//   - When full: both ready outputs are 0.
//   - When not full: ready goes to the arbitration winner.
//   - Ready for a lone valid source: 1 for that source; 1 for both when neither is valid.
//   - Winner when both are valid: RR pointer. The pointer flips to the other source after every both-valid grant.
//   - Ready is a function of registered state and v_i only. It never depends on late_wb_yumi_i.
//  Handshake: a packet is written at tail on the rising edge where v_i & ready_o = 1.
//   - The source holds pkt/v until accepted.
//  Dequeue: late_wb_yumi_i pops the head at the edge.
//   - Simultaneous enq+deq keeps the count unchanged.
//   - With count=els_p, ready stays 0 that cycle (no full bypass).
//   - An enqueue into an empty buffer is visible on late_wb_v_o the next cycle. Latency is 1, with no flow-through.
//  Pointers: wrap from els_p-1 to 0 and are compared via count, not pointer equality.
//  Force: late_wb_force_o = late_wb_v_o & (count >= force_thresh_p) [| age_force, see CONFIGURATION].
//   - Registered-state based; no combinational path from any input.
//  Order: strict FIFO across both sources. Entries are never flushed or squashed, because late writebacks belong to committed instructions.
//  Yumi without valid is an error. An assertion flags it. The RTL ignores it (no pop when count=0).
//  Packets pass through bit-exact; ird_w_v/frd_w_v/ptw_w_v are not interpreted.
// CONFIGURATION
//  BP_BE_LATE_WB_AGE_FORCE_EN defined:
//   - Age counter increments each cycle late_wb_v_o=1 & ~late_wb_yumi_i, saturating at age_limit_p.
//   - It clears to 0 on any pop or when the buffer is empty.
//   - age_force = (age == age_limit_p), OR-ed into late_wb_force_o.
//  Not defined: no age counter, and age_limit_p is unused; force comes from occupancy only.
// TESTING
//  1. Reset release, idle -> v_o=0, force_o=0, both ready=1, occupancy_o=0.
//  2. One ilong pkt (rd_addr=5, data=0xDEAD) at cycle 0:
//   - v_o=1 with identical pkt at cycle 1.
//   - yumi at cycle 1 -> v_o=0 at cycle 2.
//  3. Both sources valid every cycle, no yumi, els_p=4:
//   - Grants alternate ilong, flong, ilong, flong.
//   - force_o=1 once occupancy=3.
//   - Both ready=0 at occupancy=4; order of late_wb_pkt_o preserved on drain.
//  4. Full buffer, yumi and ilong_v both held:
//   - Cycle with count=4 has ready=0.
//   - Next cycle count=3, ready=1; enq+deq holds count at 3.
//   - After 10 more pops, pointers wrapped, data intact.
//  5. Macro on, age_limit_p=16, one entry, no yumi:
//   - force_o rises exactly 16 cycles after v_o rose.
//   - Yumi clears force next cycle.
//   - Macro off: force_o stays 0.
//  6. Assert reset_n_i with 3 entries mid-handshake -> asynchronously v_o=0, occupancy_o=0; the post-reset pop of an empty buffer is ignored.

Source files
------------

// File: rtl/bp_be_late_wb_buffer.sv
// bp_be_late_wb_buffer
//   In-order FIFO that gathers long-latency writebacks and replays them on the
//   late-writeback port of the BE scheduler. There are two sources: ilong
//   (integer/PTW data from D$ miss returns) and flong (fdiv/fsqrt results).
//   Packets are stored and returned bit-exact and are never interpreted.
//
//   wb_pkt_width_p is the width of bp_be_wb_pkt_s for the target processor
//   configuration. The default of 79 is {ird_w_v, frd_w_v, ptw_w_v,
//   rd_addr[4:0], rd_data[65:0], fflags[4:0]}.
//
//   Optional feature: define BP_BE_LATE_WB_AGE_FORCE_EN to add a head-entry
//   age counter. When the head has waited age_limit_p cycles it also raises
//   force. When the macro is undefined, force depends on occupancy only.
//
// Ports
//   clk_i, reset_n_i                clock, asynchronous active-low reset
//   ilong_pkt_i/_v_i/_ready_o       integer/PTW writeback enqueue (valid-ready)
//   flong_pkt_i/_v_i/_ready_o       FP writeback enqueue (valid-ready)
//   late_wb_pkt_o/_v_o              head packet and its valid
//   late_wb_force_o                 scheduler must take the head this cycle
//   late_wb_yumi_i                  head consumed this cycle
//   occupancy_o                     current entry count
module bp_be_late_wb_buffer #(
    parameter int unsigned wb_pkt_width_p = 79,
    parameter int unsigned els_p          = 4,
    parameter int unsigned force_thresh_p = 3,
    parameter int unsigned age_limit_p    = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [wb_pkt_width_p-1:0]    ilong_pkt_i,
    input  logic                         ilong_v_i,
    output logic                         ilong_ready_o,
    input  logic [wb_pkt_width_p-1:0]    flong_pkt_i,
    input  logic                         flong_v_i,
    output logic                         flong_ready_o,
    output logic [wb_pkt_width_p-1:0]    late_wb_pkt_o,
    output logic                         late_wb_v_o,
    output logic                         late_wb_force_o,
    input  logic                         late_wb_yumi_i,
    output logic [$clog2(els_p+1)-1:0]   occupancy_o
);

    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);
    localparam int unsigned ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    typedef enum logic {
        PRIO_ILONG = 1'b0,
        PRIO_FLONG = 1'b1
    } prio_e;

    logic [wb_pkt_width_p-1:0] mem_q [els_p];
    logic [ptr_w_lp-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]       rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]       count_q, count_d;
    prio_e                     prio_q, prio_d;

    logic                      full, empty;
    logic                      ilong_fire, flong_fire;
    logic                      enq, deq;
    logic [wb_pkt_width_p-1:0] enq_pkt;
    logic                      age_force;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full  = (count_q == cnt_w_lp'(els_p));
        empty = (count_q == '0);

        // A source is refused only when full or when it loses arbitration to
        // the other valid source. Ready never depends on yumi, so there is no
        // full-buffer bypass.
        ilong_ready_o = ~full & (~flong_v_i | (ilong_v_i & (prio_q == PRIO_ILONG)));
        flong_ready_o = ~full & (~ilong_v_i | (flong_v_i & (prio_q == PRIO_FLONG)));

        ilong_fire = ilong_v_i & ilong_ready_o;
        flong_fire = flong_v_i & flong_ready_o;
        enq        = ilong_fire | flong_fire;
        enq_pkt    = ilong_fire ? ilong_pkt_i : flong_pkt_i;
        deq        = late_wb_yumi_i & ~empty;

        wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        prio_d = prio_q;
        if (ilong_v_i & flong_v_i & ~full) begin
            prio_d = (prio_q == PRIO_ILONG) ? PRIO_FLONG : PRIO_ILONG;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            prio_q   <= PRIO_ILONG;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            prio_q   <= prio_d;
        end
    end

    // Entry storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= enq_pkt;
        end
    end

`ifdef BP_BE_LATE_WB_AGE_FORCE_EN
    localparam int unsigned age_w_lp = $clog2(age_limit_p + 1);
    localparam logic [age_w_lp-1:0] age_max_lp = age_w_lp'(age_limit_p);

    logic [age_w_lp-1:0] age_q, age_d;

    // The age counter measures how long the current head has waited. It
    // restarts on every pop and saturates at the limit.
    always_comb begin
        age_d = age_q;
        if (deq | empty) begin
            age_d = '0;
        end else if (age_q != age_max_lp) begin
            age_d = age_q + 1'b1;
        end
        age_force = (age_q == age_max_lp);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    always_comb begin
        age_force = 1'b0;
    end
`endif

    always_comb begin
        late_wb_v_o     = ~empty;
        late_wb_pkt_o   = mem_q[rd_ptr_q];
        late_wb_force_o = late_wb_v_o & ((count_q >= cnt_w_lp'(force_thresh_p)) | age_force);
        occupancy_o     = count_q;
    end

    a_params_legal: assert property (@(posedge clk_i)
        (els_p >= 2) && (force_thresh_p >= 1) && (force_thresh_p <= els_p) && (age_limit_p >= 1));

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        late_wb_yumi_i |-> late_wb_v_o);

endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
module tb_bp_be_late_wb_buffer;

    localparam int unsigned W   = 79;
    localparam int unsigned ELS = 4;
    localparam int unsigned THR = 3;
    localparam int unsigned AGE = 16;
`ifdef BP_BE_LATE_WB_AGE_FORCE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    typedef logic [W-1:0] pkt_t;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    pkt_t       ilong_pkt_i, flong_pkt_i, late_wb_pkt_o;
    logic       ilong_v_i, flong_v_i, ilong_ready_o, flong_ready_o;
    logic       late_wb_v_o, late_wb_force_o, late_wb_yumi_i;
    logic [2:0] occupancy_o;

    always #5 clk_i = ~clk_i;

    bp_be_late_wb_buffer #(
        .wb_pkt_width_p(W),
        .els_p(ELS),
        .force_thresh_p(THR),
        .age_limit_p(AGE)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .ilong_pkt_i(ilong_pkt_i),
        .ilong_v_i(ilong_v_i),
        .ilong_ready_o(ilong_ready_o),
        .flong_pkt_i(flong_pkt_i),
        .flong_v_i(flong_v_i),
        .flong_ready_o(flong_ready_o),
        .late_wb_pkt_o(late_wb_pkt_o),
        .late_wb_v_o(late_wb_v_o),
        .late_wb_force_o(late_wb_force_o),
        .late_wb_yumi_i(late_wb_yumi_i),
        .occupancy_o(occupancy_o)
    );

    int   checks = 0;
    int   errors = 0;
    pkt_t sb[$];
    int   m_count, m_age, i_seq, f_seq;
    bit   m_prio;

    typedef struct {
        bit iv, fv, y;
        bit ir, fr, v, frc;
        int occ;
    } vec_t;
    vec_t tbl[10];

    function automatic pkt_t mk(input logic [2:0] wv, input logic [4:0] rd,
                                input logic [65:0] data, input logic [4:0] ff);
        return {wv, rd, data, ff};
    endfunction

    function automatic pkt_t ipkt(input int s);
        return mk(3'b100, 5'(5 + s), 66'hDEAD + 66'(s) * 66'h10000, 5'd0);
    endfunction

    function automatic pkt_t fpkt(input int s);
        return mk(3'b010, 5'(s), 66'h3F00_0000 + 66'(s), 5'(s + 1));
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit iv, input bit fv, input bit y);
        ilong_v_i      = iv;
        ilong_pkt_i    = iv ? ipkt(i_seq) : '0;
        flong_v_i      = fv;
        flong_pkt_i    = fv ? fpkt(f_seq) : '0;
        late_wb_yumi_i = y;
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_age   = 0;
        m_prio  = 1'b0;
        i_seq   = 0;
        f_seq   = 0;
    endtask

    // Called 1 time unit after a negedge with inputs already driven: checks
    // outputs against the model, advances the model across the next posedge.
    task automatic model_step();
        bit full, er_i, er_f, pop;
        full = (m_count == ELS);
        er_i = !full && (!flong_v_i || (ilong_v_i && m_prio == 1'b0));
        er_f = !full && (!ilong_v_i || (flong_v_i && m_prio == 1'b1));
        chk("ilong_ready", ilong_ready_o, er_i);
        chk("flong_ready", flong_ready_o, er_f);
        chk("late_wb_v", late_wb_v_o, m_count != 0);
        chk("occupancy", occupancy_o, m_count);
        chk("force", late_wb_force_o,
            (m_count != 0) && ((m_count >= THR) || (AGE_EN && m_age == AGE)));
        if (m_count != 0) chk("head_pkt", late_wb_pkt_o, sb[0]);

        pop = late_wb_yumi_i && (m_count != 0);
        if (pop) void'(sb.pop_front());
        if (pop || m_count == 0) m_age = 0;
        else if (m_age < AGE) m_age++;
        if (ilong_v_i && er_i) begin
            sb.push_back(ilong_pkt_i);
            i_seq++;
            m_count++;
        end else if (flong_v_i && er_f) begin
            sb.push_back(flong_pkt_i);
            f_seq++;
            m_count++;
        end
        if (pop) m_count--;
        if (ilong_v_i && flong_v_i && !full) m_prio = ~m_prio;
        @(negedge clk_i);
    endtask

    task automatic cyc(input bit iv, input bit fv, input bit y);
        drive(iv, fv, y);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int rise;

        //           iv fv y  ir fr v  frc occ
        tbl[0] = '{1, 1, 0, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 1, 1, 0, 1};
        tbl[2] = '{1, 1, 0, 1, 0, 1, 0, 2};
        tbl[3] = '{1, 1, 0, 0, 1, 1, 1, 3};
        tbl[4] = '{1, 1, 0, 0, 0, 1, 1, 4};
        tbl[5] = '{0, 0, 1, 0, 0, 1, 1, 4};
        tbl[6] = '{0, 0, 1, 1, 1, 1, 1, 3};
        tbl[7] = '{0, 0, 1, 1, 1, 1, 0, 2};
        tbl[8] = '{0, 0, 1, 1, 1, 1, 0, 1};
        tbl[9] = '{0, 0, 0, 1, 1, 0, 0, 0};

        // Reset state, during and after reset
        model_reset();
        drive(1'b0, 1'b0, 1'b0);
        reset_n_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("rst_v", late_wb_v_o, 1'b0);
        chk("rst_force", late_wb_force_o, 1'b0);
        chk("rst_occ", occupancy_o, 0);
        chk("rst_ilong_ready", ilong_ready_o, 1'b1);
        chk("rst_flong_ready", flong_ready_o, 1'b1);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        chk("idle_v", late_wb_v_o, 1'b0);
        chk("idle_ready", {ilong_ready_o, flong_ready_o}, 2'b11);
        @(negedge clk_i);
        cyc(1'b0, 1'b0, 1'b0);

        // Single ilong packet, one-cycle latency, pop
        cyc(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        #1;
        chk("t2_v", late_wb_v_o, 1'b1);
        chk("t2_pkt", late_wb_pkt_o, mk(3'b100, 5'd5, 66'hDEAD, 5'd0));
        model_step();
        cyc(1'b0, 1'b0, 1'b0);

        // Both sources valid every cycle, then drain (table driven)
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].iv, tbl[k].fv, tbl[k].y);
            #1;
            chk($sformatf("tbl%0d_ilong_ready", k), ilong_ready_o, tbl[k].ir);
            chk($sformatf("tbl%0d_flong_ready", k), flong_ready_o, tbl[k].fr);
            chk($sformatf("tbl%0d_v", k), late_wb_v_o, tbl[k].v);
            chk($sformatf("tbl%0d_force", k), late_wb_force_o, tbl[k].frc);
            chk($sformatf("tbl%0d_occ", k), occupancy_o, tbl[k].occ);
            if (k == 5) chk("tbl_head0", late_wb_pkt_o, ipkt(0));
            if (k == 6) chk("tbl_head1", late_wb_pkt_o, fpkt(0));
            if (k == 7) chk("tbl_head2", late_wb_pkt_o, ipkt(1));
            if (k == 8) chk("tbl_head3", late_wb_pkt_o, fpkt(1));
            model_step();
        end

        // Full buffer with yumi and ilong_v held: no bypass, then wrap
        do_reset();
        repeat (4) cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            #1;
            if (k == 0) begin
                chk("t4_full_ready", ilong_ready_o, 1'b0);
                chk("t4_full_occ", occupancy_o, 4);
            end else begin
                chk("t4_hold_ready", ilong_ready_o, 1'b1);
                chk("t4_hold_occ", occupancy_o, 3);
            end
            model_step();
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // Head-entry aging
        do_reset();
        cyc(1'b1, 1'b0, 1'b0);
        rise = 999;
        for (int w = 0; w < 20; w++) begin
            drive(1'b0, 1'b0, 1'b0);
            #1;
            if (late_wb_force_o && rise == 999) rise = w;
            model_step();
        end
        chk("t5_force_rise", rise, AGE_EN ? 16 : 999);
        cyc(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        #1;
        chk("t5_force_cleared", late_wb_force_o, 1'b0);
        model_step();

        // Asynchronous reset with three entries and a handshake in flight
        do_reset();
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        #2;
        reset_n_i      = 1'b0;
        late_wb_yumi_i = 1'b1;
        #1;
        chk("t6_v", late_wb_v_o, 1'b0);
        chk("t6_occ", occupancy_o, 0);
        chk("t6_force", late_wb_force_o, 1'b0);
        chk("t6_ilong_ready", ilong_ready_o, 1'b1);
        @(negedge clk_i);
        model_reset();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
